// File: rtl/moore_pair_tx.sv
// Serial transmitter feeding the Moore pair detector; shifts a parallel frame out one bit per
// clock and predicts the detector's flag and per-frame pair count from an internal shadow FSM.
module moore_pair_tx #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             exp_flag,
    output logic [CNT_W-1:0] pair_count
);

    localparam int BCNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   shift_r;
    logic [BCNT_W-1:0]  bit_cnt_r;
    logic [1:0]         shadow_r;
    logic [1:0]         shadow_s;
    logic               enter_s;
    logic               enter_r;
    logic               accept_s;
    logic               last_s;
    logic               exp_flag_r;
    logic [CNT_W-1:0]   pair_count_r;
    logic               serial_out_r;
    logic               bit_valid_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               data_ready_r;

    // Detector transition: state 11 is the flag state and restarts pairing on the next bit.
    function automatic logic [1:0] shadow_next(input logic [1:0] cur, input logic b);
        logic [1:0] nxt;
        case (cur)
            2'b01:        nxt = b ? 2'b11 : 2'b10;
            2'b10:        nxt = b ? 2'b01 : 2'b11;
            2'b00, 2'b11: nxt = b ? 2'b01 : 2'b10;
            default:      nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Next-state, handshake and shadow FSM decode.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        enter_s  = 1'b0;
        accept_s = (state_r == IDLE) && data_ready_r && data_valid;
        last_s   = (state_r == SHIFT) && (bit_cnt_r == LAST_BIT);
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = SHIFT;
                else          state_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_s = IDLE;
                else        state_s = SHIFT;
            end
            default: state_s = IDLE;
        endcase
        if (accept_s) begin
            shadow_s = 2'b00;
        end else if (state_r == SHIFT) begin
            shadow_s = shadow_next(shadow_r, serial_out_r);
            enter_s  = (shadow_s == 2'b11);
        end else begin
            shadow_s = shadow_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Datapath, shadow tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            shadow_r     <= 2'b00;
            enter_r      <= 1'b0;
            exp_flag_r   <= 1'b0;
            pair_count_r <= '0;
            serial_out_r <= IDLE_LEVEL;
            bit_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            data_ready_r <= 1'b0;
        end else begin
            shadow_r     <= shadow_s;
            enter_r      <= enter_s;
            exp_flag_r   <= enter_r;
            data_ready_r <= (state_s == IDLE);
            busy_r       <= (state_s == SHIFT);
            bit_valid_r  <= (state_s == SHIFT);
            frame_done_r <= last_s;
            // The first bit is loaded on the accept edge so it appears in the very next cycle.
            if (accept_s) begin
                shift_r      <= advance(data_in);
                serial_out_r <= head_bit(data_in);
                bit_cnt_r    <= '0;
            end else if (last_s) begin
                shift_r      <= '0;
                serial_out_r <= IDLE_LEVEL;
                bit_cnt_r    <= '0;
            end else if (state_r == SHIFT) begin
                shift_r      <= advance(shift_r);
                serial_out_r <= head_bit(shift_r);
                bit_cnt_r    <= bit_cnt_r + BCNT_W'(1);
            end
            if (accept_s)     pair_count_r <= '0;
            else if (enter_s) pair_count_r <= pair_count_r + CNT_W'(1);
        end
    end

    assign data_ready = data_ready_r;
    assign serial_out = serial_out_r;
    assign bit_valid  = bit_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign exp_flag   = exp_flag_r;
    assign pair_count = pair_count_r;

endmodule

// File: tb/tb_moore_pair_tx.sv
// Self-checking bench for moore_pair_tx: scenario tasks plus a bit-stream scoreboard that
// independently tracks the expected flag, pair count and frame_done timing.
module tb_moore_pair_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             data_valid = 1'b0;
    logic             data_ready;
    logic             serial_out;
    logic             bit_valid;
    logic             busy;
    logic             frame_done;
    logic             exp_flag;
    logic [CNT_W-1:0] pair_count;

    int total = 0;
    int bad = 0;

    moore_pair_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .serial_out(serial_out), .bit_valid(bit_valid),
        .busy(busy), .frame_done(frame_done), .exp_flag(exp_flag), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } sb_bit_t;

    sb_bit_t    exp_q[$];
    logic       mon_en = 1'b0;
    sb_bit_t    mon_e;
    logic       mon_got;
    logic [1:0] m_sh = 2'b00;
    int         m_cnt = 0;
    logic       f1 = 1'b0;
    logic       f2 = 1'b0;
    logic       fd_exp = 1'b0;

    function automatic logic [1:0] sh_step(input logic [1:0] s, input logic b);
        case (s)
            2'b00:   return b ? 2'b01 : 2'b10;
            2'b01:   return b ? 2'b11 : 2'b10;
            2'b10:   return b ? 2'b01 : 2'b11;
            default: return b ? 2'b01 : 2'b10;
        endcase
    endfunction

    // Non-overlapping pairs: each run of equal bits contributes floor(len/2).
    function automatic int count_pairs(input logic [WIDTH-1:0] d);
        int run = 1;
        int n = 0;
        for (int i = 1; i < WIDTH; i++) begin
            if (d[i] == d[i-1]) run++;
            else begin n += run / 2; run = 1; end
        end
        return n + run / 2;
    endfunction

    task automatic push_frame(input logic [WIDTH-1:0] d);
        sb_bit_t e;
        for (int i = 0; i < WIDTH; i++) begin
            e.b = d[WIDTH-1-i];
            e.first = (i == 0);
            e.last = (i == WIDTH - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic offer(input logic [WIDTH-1:0] d);
        @(posedge clk); #1;
        data_in = d;
        data_valid = 1'b1;
        push_frame(d);
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Scoreboard: pops an expected bit whenever the DUT presents one and checks flag/count/done.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_got = 1'b0;
            total++;
            if (bit_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_bit: got bit_valid=1 serial_out=%b, expected no bit", serial_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_got = 1'b1;
                    if (mon_e.first) begin m_sh = 2'b00; m_cnt = 0; end
                    if (serial_out !== mon_e.b) begin
                        bad++;
                        $display("FAIL sb_bit: got serial_out=%b, expected %b", serial_out, mon_e.b);
                    end
                end
            end else if (serial_out !== 1'b0) begin
                bad++;
                $display("FAIL sb_idle_level: got serial_out=%b, expected 0", serial_out);
            end
            total++;
            if (exp_flag !== f2) begin
                bad++;
                $display("FAIL sb_exp_flag: got %b, expected %b at %0t", exp_flag, f2, $time);
            end
            total++;
            if (pair_count !== CNT_W'(m_cnt)) begin
                bad++;
                $display("FAIL sb_pair_count: got %0d, expected %0d", pair_count, m_cnt);
            end
            total++;
            if (frame_done !== fd_exp) begin
                bad++;
                $display("FAIL sb_frame_done: got %b, expected %b at %0t", frame_done, fd_exp, $time);
            end
            f2 = f1;
            f1 = 1'b0;
            fd_exp = 1'b0;
            if (mon_got) begin
                m_sh = sh_step(m_sh, mon_e.b);
                if (m_sh == 2'b11) begin f1 = 1'b1; m_cnt++; end
                fd_exp = mon_e.last;
            end
        end
        if (rst) begin
            exp_q.delete();
            m_sh = 2'b00; m_cnt = 0; f1 = 1'b0; f2 = 1'b0; fd_exp = 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (serial_out !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0 || exp_flag !== 1'b0
                || pair_count !== 4'd0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: got so=%b busy=%b bv=%b flag=%b pc=%0d fd=%b, expected all 0",
                         serial_out, busy, bit_valid, exp_flag, pair_count, frame_done);
            end
            if (k >= 2) begin
                total++;
                if (data_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_ready: got data_ready=%b, expected 1", data_ready);
                end
            end
        end
    endtask

    task automatic test_f0();
        logic [7:0] sv;
        logic [9:0] fv, fdv, bvv;
        logic [CNT_W-1:0] pc;
        sv = '0; fv = '0; fdv = '0; bvv = '0; pc = '0;
        offer(8'hF0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8) sv = {sv[6:0], serial_out};
            fv[k-1] = exp_flag;
            fdv[k-1] = frame_done;
            bvv[k-1] = bit_valid;
            if (k == 9) pc = pair_count;
        end
        total++;
        if (sv !== 8'hF0) begin bad++; $display("FAIL f0_bits: got %h, expected f0", sv); end
        total++;
        if (fv !== 10'h2A8) begin bad++; $display("FAIL f0_flags: got %b, expected 1010101000", fv); end
        total++;
        if (fdv !== 10'h100) begin bad++; $display("FAIL f0_done: got %b, expected 0100000000", fdv); end
        total++;
        if (bvv !== 10'h0FF) begin bad++; $display("FAIL f0_bit_valid: got %b, expected 0011111111", bvv); end
        total++;
        if (pc !== 4'd4) begin bad++; $display("FAIL f0_pairs: got %0d, expected 4", pc); end
    endtask

    task automatic test_frame(input logic [WIDTH-1:0] d);
        logic ok;
        int flags;
        flags = 0;
        fork
            offer(d);
            begin
                @(posedge clk);
                repeat (WIDTH + 3) begin @(negedge clk); if (exp_flag === 1'b1) flags++; end
            end
        join_none
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL frame_%h_done: got no frame_done, expected one", d); end
        total++;
        if (pair_count !== CNT_W'(count_pairs(d))) begin
            bad++;
            $display("FAIL frame_%h_pairs: got %0d, expected %0d", d, pair_count, count_pairs(d));
        end
        wait fork;
        if (d == 8'hAA) begin
            total++;
            if (flags != 0) begin bad++; $display("FAIL aa_flags: got %0d flags, expected 0", flags); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] bv1, fd1, bv2, fd2;
        logic [CNT_W-1:0] pc1, pc2;
        logic dr1;
        int extra;
        bv1 = '0; fd1 = '0; bv2 = '0; fd2 = '0; pc1 = '0; pc2 = '0; dr1 = 1'b0; extra = 0;
        @(posedge clk); #1;
        data_in = 8'h33; data_valid = 1'b1; push_frame(8'h33);
        @(posedge clk); #1;
        data_in = 8'hAA; push_frame(8'hAA);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bv1[k] = bit_valid; fd1[k] = frame_done;
            if (k == 8) begin pc1 = pair_count; dr1 = data_ready; end
        end
        @(posedge clk); #1 data_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bv2[k] = bit_valid; fd2[k] = frame_done;
            if (k == 8) pc2 = pair_count;
        end
        repeat (4) begin @(negedge clk); if (bit_valid === 1'b1) extra++; end
        total++;
        if (bv1 !== 9'h0FF || fd1 !== 9'h100) begin
            bad++; $display("FAIL b2b_frame1: got bv=%b fd=%b, expected 011111111/100000000", bv1, fd1);
        end
        total++;
        if (bv2 !== 9'h0FF || fd2 !== 9'h100) begin
            bad++; $display("FAIL b2b_frame2: got bv=%b fd=%b, expected 011111111/100000000", bv2, fd2);
        end
        total++;
        if (pc1 !== 4'd4 || pc2 !== 4'd0) begin
            bad++; $display("FAIL b2b_pairs: got %0d,%0d, expected 4,0", pc1, pc2);
        end
        total++;
        if (dr1 !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b, expected 1", dr1); end
        total++;
        if (extra != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra bits, expected 0", extra); end
    endtask

    task automatic test_reset_abort();
        int fds;
        logic ok;
        fds = 0;
        offer(8'hF0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (serial_out !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0 || frame_done !== 1'b0
            || pair_count !== 4'd0) begin
            bad++;
            $display("FAIL abort_state: got so=%b busy=%b bv=%b fd=%b pc=%0d, expected all 0",
                     serial_out, busy, bit_valid, frame_done, pair_count);
        end
        repeat (12) begin @(negedge clk); if (frame_done === 1'b1) fds++; end
        total++;
        if (fds != 0) begin bad++; $display("FAIL abort_done: got %0d frame_done, expected 0", fds); end
        offer(8'h33);
        wait_done(ok);
        total++;
        if (!ok || pair_count !== 4'd4) begin
            bad++; $display("FAIL abort_next: got done=%b pc=%0d, expected 1/4", ok, pair_count);
        end
    endtask

    task automatic test_rst_valid();
        int bits;
        bits = 0;
        @(posedge clk); #1;
        rst = 1'b1; data_valid = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; data_valid = 1'b0;
        repeat (12) begin @(negedge clk); if (bit_valid === 1'b1) bits++; end
        total++;
        if (bits != 0) begin bad++; $display("FAIL rst_wins: got %0d bit cycles, expected 0", bits); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_f0();
        test_frame(8'hAA);
        test_frame(8'hE7);
        test_back_to_back();
        test_reset_abort();
        test_rst_valid();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_drain: got %0d pending bits, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
